lane_accum_adder: RTL

- Parametrised successor to the single-operand combinational adder.
- Adds LANES independent signed lanes per beat, with a registered output and a valid/ready handshake.
- Two modes: elementwise A+B, or accumulate A over ACC_LEN beats to produce one partial sum per lane.
- Sits between the MAC array and the softmax/norm stages of the ViT datapath, reducing per-patch partial sums.

---
 rtl/lane_accum_if.sv | 27 ++
 rtl/lane_accum_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lane_accum_if.sv
// Lane-parallel operand/result stream bundle for lane_accum_adder.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface lane_accum_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 20,
    parameter int unsigned LANES      = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] a;
    logic [LANES*DATA_WIDTH-1:0] b;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*ACC_WIDTH-1:0]  result;
    logic                        out_last;
    logic [LANES-1:0]            sat_flag;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, out_last, sat_flag
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, out_last, sat_flag
    );
endinterface

// File: rtl/lane_accum_adder.sv
// Lane-parallel signed adder: elementwise A+B (or bypass of A), or per-lane accumulation of A
// over ACC_LEN beats. Define LANE_ACCUM_ADDER_SAT_EN for saturating sums and per-lane sat_flag.
module lane_accum_adder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 20,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ACC_LEN    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        adder_en,
    input  logic        mode,
    lane_accum_if.slave bus
);
    localparam int unsigned          CNT_WIDTH = $clog2(ACC_LEN) + 1;
    localparam logic [CNT_WIDTH-1:0] CntLast   = CNT_WIDTH'(ACC_LEN);

    typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;
    typedef logic [LANES-1:0][ACC_WIDTH-1:0] lanes_t;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    lanes_t               acc_q, acc_d;
    lanes_t               result_q, result_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    lanes_t a_ext, b_ext, ew_sum, acc_sum;
    logic   in_ready, accept, xfer, ew_beat, acc_beat, finish;

    function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] x);
        return {{(ACC_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

`ifdef LANE_ACCUM_ADDER_SAT_EN
    logic [LANES-1:0] ew_ovf, acc_ovf;
    logic [LANES-1:0] sat_q, sat_d, sat_acc_q, sat_acc_d;

    // Returns {saturated, sum}; the extra sum bit carries the true sign on overflow.
    function automatic logic [ACC_WIDTH:0] add_sat(input logic [ACC_WIDTH-1:0] x,
                                                   input logic [ACC_WIDTH-1:0] y);
        logic [ACC_WIDTH:0] wide;
        wide = {x[ACC_WIDTH-1], x} + {y[ACC_WIDTH-1], y};
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            return {1'b1, wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}};
        end
        return {1'b0, wide[ACC_WIDTH-1:0]};
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_ext[i] = sext(bus.a[i*DATA_WIDTH +: DATA_WIDTH]);
            b_ext[i] = adder_en ? sext(bus.b[i*DATA_WIDTH +: DATA_WIDTH]) : '0;
`ifdef LANE_ACCUM_ADDER_SAT_EN
            {ew_ovf[i], ew_sum[i]}   = add_sat(a_ext[i], b_ext[i]);
            {acc_ovf[i], acc_sum[i]} = add_sat(acc_q[i], a_ext[i]);
`else
            ew_sum[i]  = a_ext[i] + b_ext[i];
            acc_sum[i] = acc_q[i] + a_ext[i];
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        in_ready = !rst && clk_en && (!out_valid_q || bus.out_ready) && (state_q != StEmit);
        accept   = bus.in_valid && in_ready;
        xfer     = out_valid_q && bus.out_ready;
        ew_beat  = accept && (state_q == StIdle) && !(mode && adder_en);
        acc_beat = accept && !ew_beat;
        // acc and cnt are zero in StIdle, so the first beat needs no special casing.
        cnt_inc  = cnt_q + 1'b1;
        finish   = acc_beat && (cnt_inc == CntLast);

        if (xfer) begin
            out_valid_d = 1'b0;
        end
        if (ew_beat) begin
            result_d    = ew_sum;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
        end
        if (acc_beat) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
        end
        if (finish) begin
            result_d    = acc_sum;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
        end

        unique case (state_q)
            StIdle, StAccum: begin
                if (acc_beat) begin
                    state_d = finish ? StEmit : StAccum;
                end
            end
            StEmit: begin
                if (xfer) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef LANE_ACCUM_ADDER_SAT_EN
    // sat_acc collects saturation across the beats of one accumulation.
    always_comb begin
        sat_d     = sat_q;
        sat_acc_d = sat_acc_q;
        if (acc_beat) begin
            sat_acc_d = sat_acc_q | acc_ovf;
        end
        if (ew_beat) begin
            sat_d = ew_ovf;
        end
        if (finish) begin
            sat_d     = sat_acc_q | acc_ovf;
            sat_acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q     <= '0;
            sat_acc_q <= '0;
        end else if (clk_en) begin
            sat_q     <= sat_d;
            sat_acc_q <= sat_acc_d;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    assign bus.sat_flag = '0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.out_last  = out_last_q;
endmodule
